// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter sharing a single FIFO write port among
//             NUM_REQ requesters. Each grant is a burst of up to BURST_LEN
//             beats. Every write is gated on the FIFO full flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_wr_error_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic [2:0]                    owner_o,
    output logic                          busy_o,
    output logic                          err_o
);

    // Requester slots are padded to eight so a 3-bit owner index always
    // selects exactly one slot, whatever NUM_REQ is.
    localparam int         c_MAX_REQ   = 8;
    localparam logic [3:0] c_NUM_REQ   = 4'(NUM_REQ);
    localparam logic [3:0] c_LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [2:0] c_LAST_INIT = 3'(NUM_REQ - 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_BURST = 1'b1;

    logic [0:0] r_state;
    logic [2:0] r_owner;
    logic [2:0] r_last;
    logic [3:0] r_beat_cnt;
    logic       r_busy;
    logic       r_err;

    wire  [c_MAX_REQ-1:0]  w_req_ext;
    wire  [DATA_WIDTH-1:0] w_data_arr [c_MAX_REQ];
    logic                  w_own_req;
    logic                  w_accept;
    logic                  w_found;
    logic [2:0]            w_sel;
    logic [3:0]            w_sum;

    // Spread requests and data slices into fixed eight-entry tables.
    for (genvar k = 0; k < c_MAX_REQ; k++) begin : g_slot
        if (k < NUM_REQ) begin : g_used
            assign w_req_ext[k]  = req_i[k];
            assign w_data_arr[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_unused
            assign w_req_ext[k]  = 1'b0;
            assign w_data_arr[k] = '0;
        end
    end

    // Pick the first requester after the previous owner, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_sum = {1'b0, r_last} + 4'(i);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_found && w_req_ext[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[2:0];
            end
        end
    end

    // A beat is accepted only for the owner, only when the FIFO has room,
    // and never while reset is asserted.
    assign w_own_req = w_req_ext[r_owner];
    assign w_accept  = (r_state == c_S_BURST) && w_own_req && !fifo_full_i && !rst_i;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_gnt
        assign gnt_o[k] = w_accept && (r_owner == 3'(k));
    end

    assign fifo_wr_en_o = w_accept;
    assign fifo_wdata_o = w_data_arr[r_owner];
    assign owner_o      = r_owner;
    assign busy_o       = r_busy;
    assign err_o        = r_err;

    // Arbitration/burst state machine with the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_S_IDLE;
            r_owner    <= '0;
            r_last     <= c_LAST_INIT;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (fifo_wr_error_i) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_owner    <= w_sel;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_S_BURST;
                    end
                end
                c_S_BURST: begin
                    if (!w_own_req) begin
                        // Owner released early; full flag is irrelevant here.
                        r_last     <= r_owner;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= c_S_IDLE;
                    end else if (w_accept) begin
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_last     <= r_owner;
                            r_beat_cnt <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= c_S_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end
                    // Otherwise stalled on full: hold everything.
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
